// File: rtl/rxuart_ctrl_if.sv
// Consumer read handshake between rxuart_ctrl and whatever drains its FIFO.
// master: the controller, which drives the FIFO head out.
// slave:  the consumer, which accepts bytes with i_rd_ready.
interface rxuart_ctrl_if;
   logic       o_rd_valid;
   logic       i_rd_ready;
   logic [7:0] o_rd_data;

   modport master (output o_rd_valid, output o_rd_data, input  i_rd_ready);
   modport slave  (input  o_rd_valid, input  o_rd_data, output i_rd_ready);
endinterface

// File: rtl/rxuart_ctrl.sv
// rxuart_ctrl: supervises a UART receiver and buffers its bytes.
// - Holds the receiver in reset for 4 cycles after reset or a setup write.
// - Queues clean bytes received in RUN into a first-word fall-through FIFO.
// - Tracks a sticky overflow flag and, optionally, a count of errored bytes.
// Optional feature: define RXUART_CTRL_ERRCNT_EN to build the saturating
// errored-byte counter; otherwise o_err_count is tied to zero.
module rxuart_ctrl #(
   parameter int          FIFO_LG       = 4,
   parameter logic [29:0] INITIAL_SETUP = 30'd868
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_setup_wr,
   input  logic [29:0]        i_setup,
   output logic [29:0]        o_setup,
   output logic               o_rx_reset,
   input  logic               i_rx_wr,
   input  logic               i_rx_break,
   input  logic               i_rx_parity_err,
   input  logic               i_rx_frame_err,
   input  logic [7:0]         i_rx_data,
   rxuart_ctrl_if.master      rd,
   output logic [FIFO_LG:0]   o_fill,
   output logic               o_overflow,
   output logic [7:0]         o_err_count,
   input  logic               i_clr_status
);

   localparam logic [FIFO_LG:0] DEPTH = {1'b1, {FIFO_LG{1'b0}}};

   typedef enum logic [1:0] {
      ST_RST = 2'd0,
      ST_RUN = 2'd1,
      ST_BRK = 2'd2
   } state_t;

   state_t             state;
   logic [1:0]         rst_cnt;
   logic [7:0]         mem [0:(1<<FIFO_LG)-1];
   logic [FIFO_LG-1:0] wr_ptr;
   logic [FIFO_LG-1:0] rd_ptr;
   logic               full;
   logic               byte_err;
   logic               push_req;
   logic               do_push;
   logic               do_pop;

   // Byte strobe qualification; a setup write flushes, so it also blocks pushes.
   always_comb begin
      full     = (o_fill == DEPTH);
      byte_err = i_rx_parity_err | i_rx_frame_err;
      push_req = i_rx_wr && (state == ST_RUN) && !byte_err && !i_setup_wr;
      do_pop   = rd.o_rd_valid && rd.i_rd_ready && !i_setup_wr;
      // When full, a simultaneous pop frees the slot, so the push still lands.
      do_push  = push_req && (!full || do_pop);
   end

   assign rd.o_rd_valid = (o_fill != '0);
   assign rd.o_rd_data  = mem[rd_ptr];

   // Control FSM: receiver reset window, run, and line-break hold-off.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state      <= ST_RST;
         rst_cnt    <= 2'd0;
         o_rx_reset <= 1'b1;
         o_setup    <= INITIAL_SETUP;
      end else if (i_setup_wr) begin
         // New setup: reload and restart the 4-cycle receiver reset.
         state      <= ST_RST;
         rst_cnt    <= 2'd0;
         o_rx_reset <= 1'b1;
         o_setup    <= i_setup;
      end else begin
         case (state)
            ST_RST: begin
               if (rst_cnt == 2'd3) begin
                  state      <= ST_RUN;
                  o_rx_reset <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt + 2'd1;
               end
            end
            ST_RUN: if (i_rx_break)  state <= ST_BRK;
            ST_BRK: if (!i_rx_break) state <= ST_RUN;
            default: begin
               state      <= ST_RST;
               rst_cnt    <= 2'd0;
               o_rx_reset <= 1'b1;
            end
         endcase
      end
   end

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_rx_data;
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_fill     <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (i_setup_wr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_fill <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      o_fill <= o_fill + 1'b1;
            else if (do_pop && !do_push) o_fill <= o_fill - 1'b1;
         end
         // Clear first so a same-cycle overflow event wins.
         if (i_clr_status) o_overflow <= 1'b0;
         if (push_req && full && !do_pop) o_overflow <= 1'b1;
      end
   end

`ifdef RXUART_CTRL_ERRCNT_EN
   logic err_evt;
   assign err_evt = i_rx_wr && (state == ST_RUN) && byte_err && !i_setup_wr;

   // Saturating count of errored bytes; an increment beats a same-cycle clear.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_err_count <= 8'd0;
      end else if (err_evt) begin
         if (i_clr_status)               o_err_count <= 8'd1;
         else if (o_err_count != 8'hFF)  o_err_count <= o_err_count + 8'd1;
      end else if (i_clr_status) begin
         o_err_count <= 8'd0;
      end
   end
`else
   assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_rxuart_ctrl.sv
// Directed bench for rxuart_ctrl: reset window, FIFO ordering, overflow,
// errored-byte discard, setup reload and line-break handling.
module tb_rxuart_ctrl;
   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_setup_wr;
   logic [29:0] i_setup;
   logic [29:0] o_setup;
   logic        o_rx_reset;
   logic        i_rx_wr, i_rx_break, i_rx_parity_err, i_rx_frame_err;
   logic [7:0]  i_rx_data;
   logic [4:0]  o_fill;
   logic        o_overflow;
   logic [7:0]  o_err_count;
   logic        i_clr_status;
   int          errors = 0;
   int          checks = 0;

   rxuart_ctrl_if rd_if ();

   rxuart_ctrl dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_setup_wr(i_setup_wr),
      .i_setup(i_setup), .o_setup(o_setup), .o_rx_reset(o_rx_reset),
      .i_rx_wr(i_rx_wr), .i_rx_break(i_rx_break),
      .i_rx_parity_err(i_rx_parity_err), .i_rx_frame_err(i_rx_frame_err),
      .i_rx_data(i_rx_data), .rd(rd_if.master), .o_fill(o_fill),
      .o_overflow(o_overflow), .o_err_count(o_err_count),
      .i_clr_status(i_clr_status)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic perr, input logic ferr);
      i_rx_wr = 1'b1; i_rx_data = d; i_rx_parity_err = perr; i_rx_frame_err = ferr;
      tick();
      i_rx_wr = 1'b0; i_rx_parity_err = 1'b0; i_rx_frame_err = 1'b0;
   endtask

   task automatic setup(input logic [29:0] v);
      i_setup_wr = 1'b1; i_setup = v;
      tick();
      i_setup_wr = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_err;
      i_reset_n = 1'b0; i_setup_wr = 1'b0; i_setup = '0; i_rx_wr = 1'b0;
      i_rx_break = 1'b0; i_rx_parity_err = 1'b0; i_rx_frame_err = 1'b0;
      i_rx_data = '0; i_clr_status = 1'b0; rd_if.i_rd_ready = 1'b0;
      tick(); tick();
      chk("rst_rx_reset", o_rx_reset, 1);
      chk("rst_setup", o_setup, 868);
      chk("rst_fill", o_fill, 0);
      chk("rst_valid", rd_if.o_rd_valid, 0);
      chk("rst_ovf", o_overflow, 0);
      chk("rst_errcnt", o_err_count, 0);

      // Receiver reset window: 4 cycles high from the last reset edge.
      i_reset_n = 1'b1;
      chk("win_c1", o_rx_reset, 1);
      tick(); chk("win_c2", o_rx_reset, 1);
      tick(); chk("win_c3", o_rx_reset, 1);
      tick(); chk("win_c4", o_rx_reset, 1);
      tick(); chk("win_done", o_rx_reset, 0);

      // Three clean bytes, then drain in order.
      send(8'h41, 0, 0); send(8'h42, 0, 0); send(8'h43, 0, 0);
      chk("q3_fill", o_fill, 3);
      chk("q3_valid", rd_if.o_rd_valid, 1);
      chk("q3_head", rd_if.o_rd_data, 8'h41);
      rd_if.i_rd_ready = 1'b1;
      chk("rd_41", rd_if.o_rd_data, 8'h41);
      tick(); chk("rd_42", rd_if.o_rd_data, 8'h42);
      tick(); chk("rd_43", rd_if.o_rd_data, 8'h43);
      tick(); chk("rd_empty_valid", rd_if.o_rd_valid, 0);
      chk("rd_empty_fill", o_fill, 0);
      // Ready with empty FIFO must not underflow.
      tick(); chk("rd_empty_hold", o_fill, 0);
      rd_if.i_rd_ready = 1'b0;

      // Errored bytes are discarded and counted when the counter is built.
`ifdef RXUART_CTRL_ERRCNT_EN
      exp_err = 8'd1;
`else
      exp_err = 8'd0;
`endif
      send(8'h55, 0, 1);
      chk("ferr_fill", o_fill, 0);
      chk("ferr_cnt", o_err_count, exp_err);
      send(8'h56, 1, 0);
      chk("perr_fill", o_fill, 0);
      chk("perr_cnt", o_err_count, exp_err * 2);
      // Increment beats a same-cycle clear.
      i_clr_status = 1'b1;
      send(8'h57, 0, 1);
      chk("clr_vs_inc", o_err_count, exp_err);
      tick(); i_clr_status = 1'b0;
      chk("errcnt_clr", o_err_count, 0);

      // 17 bytes into a 16-deep FIFO: last one dropped, overflow sticks.
      for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 0, 0);
      chk("full_fill", o_fill, 16);
      chk("full_ovf0", o_overflow, 0);
      i_clr_status = 1'b1;
      send(8'hEE, 0, 0);
      i_clr_status = 1'b0;
      chk("ovf_fill", o_fill, 16);
      chk("ovf_set_beats_clr", o_overflow, 1);
      chk("ovf_head", rd_if.o_rd_data, 8'h10);
      i_clr_status = 1'b1; tick(); i_clr_status = 1'b0;
      chk("ovf_clr", o_overflow, 0);
      // Push and pop together while full: both succeed, no overflow.
      rd_if.i_rd_ready = 1'b1;
      send(8'hAA, 0, 0);
      rd_if.i_rd_ready = 1'b0;
      chk("fullpp_fill", o_fill, 16);
      chk("fullpp_ovf", o_overflow, 0);
      rd_if.i_rd_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("drain_%0d", i), rd_if.o_rd_data, 8'h10 + 8'(i));
         tick();
      end
      chk("drain_last", rd_if.o_rd_data, 8'hAA);
      tick();
      chk("drain_empty", o_fill, 0);
      rd_if.i_rd_ready = 1'b0;

      // Setup write flushes and restarts the receiver reset window.
      for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 0, 0);
      chk("pre_setup_fill", o_fill, 5);
      setup(30'd434);
      chk("setup_val", o_setup, 434);
      chk("setup_flush", o_fill, 0);
      chk("setup_rx_c1", o_rx_reset, 1);
      send(8'h99, 0, 0);
      chk("rst_drop", o_fill, 0);
      chk("setup_rx_c2", o_rx_reset, 1);
      tick(); chk("setup_rx_c3", o_rx_reset, 1);
      tick(); chk("setup_rx_c4", o_rx_reset, 1);
      tick(); chk("setup_rx_done", o_rx_reset, 0);

      // A setup write inside the window restarts the count.
      setup(30'd868);
      tick();
      setup(30'd434);
      chk("restart_setup", o_setup, 434);
      chk("restart_c1", o_rx_reset, 1);
      tick(); chk("restart_c2", o_rx_reset, 1);
      tick(); chk("restart_c3", o_rx_reset, 1);
      tick(); chk("restart_c4", o_rx_reset, 1);
      tick(); chk("restart_done", o_rx_reset, 0);

      // Line break: bytes dropped while in BRK, accepted after it clears.
      i_rx_break = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) send(8'h30 + 8'(i), 0, 0);
         else tick();
      end
      chk("brk_fill", o_fill, 0);
      i_rx_break = 1'b0;
      tick();
      send(8'h77, 0, 0);
      chk("post_brk_fill", o_fill, 1);
      chk("post_brk_data", rd_if.o_rd_data, 8'h77);

      // Reset wins over a simultaneous setup write.
      i_reset_n = 1'b0;
      setup(30'd434);
      chk("rstpri_setup", o_setup, 868);
      chk("rstpri_fill", o_fill, 0);
      chk("rstpri_rx", o_rx_reset, 1);
      i_reset_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
